uart_rx_ctrl: RTL and testbench

Receive-side controller placed between the UART receiver FSM and the consuming logic. It captures each error-free received word into an internal FIFO and presents it on a valid/ready interface. It classifies and counts error frames, and drives the outgoing RTS line with threshold-based hardware flow control. Overruns are detected and latched until software clears them.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_fifo.sv | 77 +++++++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive-side controller.
package uart_pkg;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    THROTTLE = 2'd1,
    OVERRUN  = 2'd2
  } Rx_Ctrl_States;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with a registered storage array and a head word read straight from it.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head word reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers good words, counts error frames, latches overruns
// and drives RTS with hysteresis around the FIFO occupancy.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_HIGH   = 6,
  parameter int RTS_LOW    = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Rx_Rdy_In,
  input  logic [DATA_BITS-1:0]          Rx_Data_In,
  input  logic [2:0]                    Rx_Error_In,
  input  logic                          RTS_In,
  output logic                          RTS_Out,
  output logic [DATA_BITS-1:0]          Data_Out,
  output logic                          Valid_Out,
  input  logic                          Ready_In,
  input  logic                          Clr_Err_In,
  output logic                          Overrun_Out,
  output logic [ERR_CNT_W-1:0]          Break_Cnt,
  output logic [ERR_CNT_W-1:0]          Parity_Cnt,
  output logic [ERR_CNT_W-1:0]          Frame_Cnt,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_Out
);

  import uart_pkg::*;

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  Rx_Ctrl_States       state_q, state_d;
  logic                rts_q, rts_d;
  logic                overrun_q, overrun_d;
  logic                clr_seen_q, clr_seen_d;
  logic [ERR_CNT_W-1:0] break_cnt_q, break_cnt_d;
  logic [ERR_CNT_W-1:0] parity_cnt_q, parity_cnt_d;
  logic [ERR_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                push_s, pop_s, push_ok_s, drop_s;
  logic                full_s, empty_s;
  logic [FW-1:0]       fill_s, fill_next_s;

  // A clear that collides with a new error leaves the counter at one.
  function automatic logic [ERR_CNT_W-1:0] next_cnt(input logic [ERR_CNT_W-1:0] cur,
                                                    input logic hit, input logic clr);
    if (hit) begin
      if (clr)       return CNT_ONE;
      else if (&cur) return cur;
      else           return cur + CNT_ONE;
    end else if (clr) begin
      return {ERR_CNT_W{1'b0}};
    end else begin
      return cur;
    end
  endfunction

  assign push_s    = Rx_Rdy_In & (Rx_Error_In == 3'b000);
  assign pop_s     = ~empty_s & Ready_In;
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;

  rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (Rx_Data_In),
    .rdata (Data_Out),
    .full  (full_s),
    .empty (empty_s),
    .count (fill_s)
  );

  // Flow-control FSM, error counters and overrun latch next-state.
  always_comb begin
    state_d      = state_q;
    clr_seen_d   = clr_seen_q;
    fill_next_s  = fill_s;
    case ({push_ok_s, pop_s})
      2'b10:   fill_next_s = fill_s + FW'(1'b1);
      2'b01:   fill_next_s = fill_s - FW'(1'b1);
      default: fill_next_s = fill_s;
    endcase
    case (state_q)
      RUN: begin
        if (drop_s)                              state_d = OVERRUN;
        else if (fill_next_s >= FW'(RTS_HIGH))   state_d = THROTTLE;
        else                                     state_d = RUN;
      end
      THROTTLE: begin
        if (drop_s)                              state_d = OVERRUN;
        else if (fill_next_s <= FW'(RTS_LOW))    state_d = RUN;
        else                                     state_d = THROTTLE;
      end
      OVERRUN: begin
        if (drop_s)                              state_d = OVERRUN;
        else if ((fill_next_s == {FW{1'b0}}) && (Clr_Err_In || clr_seen_q))
                                                 state_d = RUN;
        else                                     state_d = OVERRUN;
      end
      default: state_d = RUN;
    endcase
    clr_seen_d   = (state_d == OVERRUN) & (clr_seen_q | Clr_Err_In) & ~drop_s;
    rts_d        = RTS_In & (state_d == RUN);
    overrun_d    = drop_s | (overrun_q & ~Clr_Err_In);
    break_cnt_d  = next_cnt(break_cnt_q,  Rx_Error_In[ERR_BREAK],  Clr_Err_In);
    parity_cnt_d = next_cnt(parity_cnt_q, Rx_Error_In[ERR_PARITY], Clr_Err_In);
    frame_cnt_d  = next_cnt(frame_cnt_q,  Rx_Error_In[ERR_FRAME],  Clr_Err_In);
  end

  // Control registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= RUN;
      clr_seen_q   <= 1'b0;
      rts_q        <= 1'b0;
      overrun_q    <= 1'b0;
      break_cnt_q  <= {ERR_CNT_W{1'b0}};
      parity_cnt_q <= {ERR_CNT_W{1'b0}};
      frame_cnt_q  <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      clr_seen_q   <= clr_seen_d;
      rts_q        <= rts_d;
      overrun_q    <= overrun_d;
      break_cnt_q  <= break_cnt_d;
      parity_cnt_q <= parity_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign RTS_Out     = rts_q;
  assign Overrun_Out = overrun_q;
  assign Break_Cnt   = break_cnt_q;
  assign Parity_Cnt  = parity_cnt_q;
  assign Frame_Cnt   = frame_cnt_q;
  assign Valid_Out   = ~empty_s;
  assign Fill_Out    = fill_s;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with default parameters.
module tb_uart_rx_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, Rx_Rdy_In, RTS_In, Ready_In, Clr_Err_In;
  logic [7:0] Rx_Data_In;
  logic [2:0] Rx_Error_In;
  logic       RTS_Out, Valid_Out, Overrun_Out;
  logic [7:0] Data_Out, Break_Cnt, Parity_Cnt, Frame_Cnt;
  logic [3:0] Fill_Out;

  int vectors    = 0;
  int miscompares = 0;

  uart_rx_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rx_Rdy_In(Rx_Rdy_In), .Rx_Data_In(Rx_Data_In),
    .Rx_Error_In(Rx_Error_In), .RTS_In(RTS_In), .RTS_Out(RTS_Out),
    .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Ready_In(Ready_In),
    .Clr_Err_In(Clr_Err_In), .Overrun_Out(Overrun_Out), .Break_Cnt(Break_Cnt),
    .Parity_Cnt(Parity_Cnt), .Frame_Cnt(Frame_Cnt), .Fill_Out(Fill_Out)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Rx_Rdy_In = 1'b0; Rx_Data_In = 8'h00; Rx_Error_In = 3'b000;
    RTS_In = 1'b1; Ready_In = 1'b0; Clr_Err_In = 1'b0;
    tick(); tick();
    vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL rst_rts: got %b exp 0", RTS_Out); end
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b exp 0", Valid_Out); end
    vectors++; if (Data_Out !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h exp 00", Data_Out); end
    vectors++; if (Fill_Out !== 4'd0) begin miscompares++; $display("FAIL rst_fill: got %0d exp 0", Fill_Out); end
    vectors++; if ({Overrun_Out, Break_Cnt, Parity_Cnt, Frame_Cnt} !== 25'd0) begin
      miscompares++; $display("FAIL rst_errs: got ovr=%b b=%0d p=%0d f=%0d exp all 0", Overrun_Out, Break_Cnt, Parity_Cnt, Frame_Cnt);
    end
    Rst = 1'b0;
    tick();
    vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL rts_after_rst: got %b exp 1", RTS_Out); end
  endtask

  task automatic test_passthrough();
    Ready_In = 1'b1; Rx_Rdy_In = 1'b1; Rx_Data_In = 8'hA5;
    tick();
    Rx_Rdy_In = 1'b0;
    vectors++; if (Valid_Out !== 1'b1) begin miscompares++; $display("FAIL pt_valid: got %b exp 1", Valid_Out); end
    vectors++; if (Data_Out !== 8'hA5) begin miscompares++; $display("FAIL pt_data: got %h exp a5", Data_Out); end
    tick();
    vectors++; if (Fill_Out !== 4'd0) begin miscompares++; $display("FAIL pt_fill: got %0d exp 0", Fill_Out); end
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL pt_valid_after: got %b exp 0", Valid_Out); end
    Ready_In = 1'b0;
  endtask

  task automatic test_error_filter();
    Rx_Error_In = 3'b101;
    tick();
    Rx_Error_In = 3'b000;
    vectors++; if (Break_Cnt !== 8'd1) begin miscompares++; $display("FAIL ef_break1: got %0d exp 1", Break_Cnt); end
    vectors++; if (Frame_Cnt !== 8'd1) begin miscompares++; $display("FAIL ef_frame1: got %0d exp 1", Frame_Cnt); end
    vectors++; if (Parity_Cnt !== 8'd0) begin miscompares++; $display("FAIL ef_parity0: got %0d exp 0", Parity_Cnt); end
    vectors++; if (Fill_Out !== 4'd0) begin miscompares++; $display("FAIL ef_fill: got %0d exp 0", Fill_Out); end
    Rx_Error_In = 3'b101;
    for (int i = 0; i < 300; i++) tick();
    Rx_Error_In = 3'b000;
    vectors++; if (Break_Cnt !== 8'd255) begin miscompares++; $display("FAIL ef_break_sat: got %0d exp 255", Break_Cnt); end
    vectors++; if (Frame_Cnt !== 8'd255) begin miscompares++; $display("FAIL ef_frame_sat: got %0d exp 255", Frame_Cnt); end
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL ef_valid: got %b exp 0", Valid_Out); end
    Clr_Err_In = 1'b1;
    tick();
    Clr_Err_In = 1'b0;
    vectors++; if ({Break_Cnt, Frame_Cnt} !== 16'd0) begin
      miscompares++; $display("FAIL ef_clear: got b=%0d f=%0d exp 0 0", Break_Cnt, Frame_Cnt);
    end
  endtask

  task automatic test_throttle();
    Ready_In = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      Rx_Rdy_In = 1'b1; Rx_Data_In = 8'(i);
      tick();
      if (i == 5) begin
        vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL thr_rts_at5: got %b exp 1", RTS_Out); end
      end
    end
    Rx_Rdy_In = 1'b0;
    vectors++; if (Fill_Out !== 4'd6) begin miscompares++; $display("FAIL thr_fill6: got %0d exp 6", Fill_Out); end
    vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL thr_rts_at6: got %b exp 0", RTS_Out); end
    Ready_In = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      vectors++; if (Data_Out !== 8'(i)) begin miscompares++; $display("FAIL thr_pop_data%0d: got %h exp %h", i, Data_Out, 8'(i)); end
      tick();
      if (i == 3) begin
        vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL thr_rts_fill3: got %b exp 0", RTS_Out); end
      end
      if (i == 4) begin
        vectors++; if (Fill_Out !== 4'd2) begin miscompares++; $display("FAIL thr_fill2: got %0d exp 2", Fill_Out); end
        vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL thr_rts_fill2: got %b exp 1", RTS_Out); end
      end
    end
    Ready_In = 1'b0;
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      Rx_Rdy_In = 1'b1; Rx_Data_In = 8'(i);
      tick();
      if (i == 8) begin
        vectors++; if (Overrun_Out !== 1'b0) begin miscompares++; $display("FAIL ovr_early: got %b exp 0", Overrun_Out); end
      end
    end
    Rx_Rdy_In = 1'b0;
    vectors++; if (Fill_Out !== 4'd8) begin miscompares++; $display("FAIL ovr_fill: got %0d exp 8", Fill_Out); end
    vectors++; if (Overrun_Out !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b exp 1", Overrun_Out); end
    vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL ovr_rts: got %b exp 0", RTS_Out); end
    Ready_In = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++; if (Data_Out !== 8'(i)) begin miscompares++; $display("FAIL ovr_drain%0d: got %h exp %h", i, Data_Out, 8'(i)); end
      tick();
    end
    Ready_In = 1'b0;
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b exp 0", Valid_Out); end
    vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL ovr_rts_held: got %b exp 0", RTS_Out); end
    Clr_Err_In = 1'b1;
    tick();
    Clr_Err_In = 1'b0;
    vectors++; if (Overrun_Out !== 1'b0) begin miscompares++; $display("FAIL ovr_cleared: got %b exp 0", Overrun_Out); end
    vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL ovr_rts_back: got %b exp 1", RTS_Out); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      Rx_Rdy_In = 1'b1; Rx_Data_In = 8'h10 + 8'(i);
      tick();
    end
    vectors++; if (Fill_Out !== 4'd8) begin miscompares++; $display("FAIL fpp_full: got %0d exp 8", Fill_Out); end
    Rx_Data_In = 8'h3C; Ready_In = 1'b1;
    tick();
    Rx_Rdy_In = 1'b0;
    vectors++; if (Fill_Out !== 4'd8) begin miscompares++; $display("FAIL fpp_fill: got %0d exp 8", Fill_Out); end
    vectors++; if (Overrun_Out !== 1'b0) begin miscompares++; $display("FAIL fpp_ovr: got %b exp 0", Overrun_Out); end
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h3C};
    for (int i = 0; i < 8; i++) begin
      vectors++; if (Data_Out !== exp_q[i]) begin miscompares++; $display("FAIL fpp_data%0d: got %h exp %h", i, Data_Out, exp_q[i]); end
      tick();
    end
    Ready_In = 1'b0;
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL fpp_empty: got %b exp 0", Valid_Out); end
    vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL fpp_rts: got %b exp 1", RTS_Out); end
  endtask

  task automatic test_clear_collision();
    Rx_Error_In = 3'b010;
    tick(); tick();
    vectors++; if (Parity_Cnt !== 8'd2) begin miscompares++; $display("FAIL cc_parity2: got %0d exp 2", Parity_Cnt); end
    Clr_Err_In = 1'b1;
    tick();
    Clr_Err_In = 1'b0; Rx_Error_In = 3'b000;
    vectors++; if (Parity_Cnt !== 8'd1) begin miscompares++; $display("FAIL cc_parity1: got %0d exp 1", Parity_Cnt); end
    vectors++; if (Break_Cnt !== 8'd0) begin miscompares++; $display("FAIL cc_break0: got %0d exp 0", Break_Cnt); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      Rx_Rdy_In = 1'b1; Rx_Data_In = 8'hC0 + 8'(i);
      tick();
    end
    Rx_Rdy_In = 1'b0;
    vectors++; if (Fill_Out !== 4'd5) begin miscompares++; $display("FAIL rm_fill5: got %0d exp 5", Fill_Out); end
    Rst = 1'b1;
    tick();
    vectors++; if (Valid_Out !== 1'b0) begin miscompares++; $display("FAIL rm_valid: got %b exp 0", Valid_Out); end
    vectors++; if (Fill_Out !== 4'd0) begin miscompares++; $display("FAIL rm_fill0: got %0d exp 0", Fill_Out); end
    vectors++; if (Data_Out !== 8'h00) begin miscompares++; $display("FAIL rm_data: got %h exp 00", Data_Out); end
    vectors++; if (Parity_Cnt !== 8'd0) begin miscompares++; $display("FAIL rm_parity: got %0d exp 0", Parity_Cnt); end
    vectors++; if (RTS_Out !== 1'b0) begin miscompares++; $display("FAIL rm_rts: got %b exp 0", RTS_Out); end
    Rst = 1'b0;
    tick();
    vectors++; if (RTS_Out !== 1'b1) begin miscompares++; $display("FAIL rm_rts_back: got %b exp 1", RTS_Out); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_error_filter();
    test_throttle();
    test_overrun();
    test_full_push_pop();
    test_clear_collision();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
